rv32_rf_port_arbiter: RTL

Shares the single write port and the s1 read port of the 5-stage core's register file between the writeback stage, a debug requester, and a built-in clear sequencer. Sits between the writeback/decode stages, the debug module, and the register file. Writeback always has write priority. Debug reads and register-file clears borrow the read port by stalling the core.

---
 rtl/rv32_rf_pkg.sv | 21 ++
 rtl/rv32_rf_port_arbiter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/rv32_rf_pkg.sv
// Shared sizes and FSM state encoding for the register-file port arbiter.
package rv32_rf_pkg;

  localparam int unsigned REG_COUNT = 32;
  localparam int unsigned REG_AW    = 5;
  localparam int unsigned XLEN      = 32;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RD_ISSUE   = 3'd1,
    RD_CAPT    = 3'd2,
    RD_RESTORE = 3'd3,
    CLEAR      = 3'd4
  } rf_arb_state_t;

  // The arbiter steers the s1 read select only while the debug address is in flight.
  function automatic logic owns_read_port(input rf_arb_state_t st);
    return (st == RD_ISSUE) || (st == RD_CAPT);
  endfunction

endpackage

// File: rtl/rv32_rf_port_arbiter.sv
// Shares the register-file write port and s1 read port between writeback,
// a debug requester and the clear sequencer; writeback always wins the write port.
module rv32_rf_port_arbiter
  import rv32_rf_pkg::*;
#(
  parameter int unsigned CLR_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_write_reg,
  input  logic [REG_AW-1:0] wb_sel_d1,
  input  logic [XLEN-1:0]   wb_reg_d1,
  input  logic [REG_AW-1:0] core_sel_s1,
  output logic              core_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [REG_AW-1:0] dbg_addr,
  input  logic [XLEN-1:0]   dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [XLEN-1:0]   dbg_rdata,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              rf_write_reg,
  output logic [REG_AW-1:0] rf_sel_d1,
  output logic [XLEN-1:0]   rf_reg_d1,
  output logic [REG_AW-1:0] rf_sel_s1,
  input  logic [XLEN-1:0]   rf_reg_s1
);

  localparam logic [REG_AW-1:0] FIRST_IDX = REG_AW'(CLR_FIRST);
  localparam logic [REG_AW-1:0] LAST_IDX  = REG_AW'(REG_COUNT - 1);

  rf_arb_state_t     state_q;
  logic [REG_AW-1:0] cnt_q;
  logic [REG_AW-1:0] addr_q;
  logic [XLEN-1:0]   rdata_q;

  logic idle_s;
  logic clr_start_s;
  logic dbg_wr_gnt_s;
  logic dbg_rd_gnt_s;
  logic clr_step_s;
  logic clr_last_s;

  // Grant decode; gated by rst so nothing is granted while the block is held in reset.
  always_comb begin
    idle_s       = (state_q == IDLE) && !rst;
    clr_start_s  = idle_s && clr_req;
    dbg_wr_gnt_s = idle_s && !clr_req && dbg_req && dbg_we && !wb_write_reg;
    dbg_rd_gnt_s = idle_s && !clr_req && dbg_req && !dbg_we;
    clr_step_s   = (state_q == CLEAR) && !wb_write_reg;
    clr_last_s   = clr_step_s && (cnt_q == LAST_IDX);
  end

  // Write-port mux: writeback, then clear, then debug write.
  always_comb begin
    rf_write_reg = 1'b0;
    rf_sel_d1    = wb_sel_d1;
    rf_reg_d1    = wb_reg_d1;
    if (wb_write_reg) begin
      rf_write_reg = 1'b1;
    end else if (clr_step_s) begin
      rf_write_reg = (cnt_q != {REG_AW{1'b0}});
      rf_sel_d1    = cnt_q;
      rf_reg_d1    = {XLEN{1'b0}};
    end else if (dbg_wr_gnt_s) begin
      rf_write_reg = 1'b1;
      rf_sel_d1    = dbg_addr;
      rf_reg_d1    = dbg_wdata;
    end else begin
      rf_write_reg = 1'b0;
    end
  end

  // Arbiter FSM with clear counter, captured debug address and read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= {REG_AW{1'b0}};
      addr_q  <= {REG_AW{1'b0}};
      rdata_q <= {XLEN{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (clr_start_s) begin
            state_q <= CLEAR;
            cnt_q   <= FIRST_IDX;
          end else if (dbg_rd_gnt_s) begin
            state_q <= RD_ISSUE;
            addr_q  <= dbg_addr;
          end else begin
            state_q <= IDLE;
          end
        end
        RD_ISSUE:   state_q <= RD_CAPT;
        RD_CAPT: begin
          // rf_reg_s1 carries the RF bypass, so a writeback this cycle is returned.
          rdata_q <= rf_reg_s1;
          state_q <= RD_RESTORE;
        end
        RD_RESTORE: state_q <= IDLE;
        CLEAR: begin
          if (clr_last_s) begin
            state_q <= IDLE;
          end else if (clr_step_s) begin
            cnt_q <= cnt_q + REG_AW'(1);
          end else begin
            state_q <= CLEAR;
          end
        end
        default:    state_q <= IDLE;
      endcase
    end
  end

  assign rf_sel_s1  = owns_read_port(state_q) ? addr_q : core_sel_s1;
  assign core_stall = (state_q != IDLE);
  assign clr_busy   = (state_q == CLEAR);
  assign clr_done   = clr_last_s;
  assign dbg_rvalid = (state_q == RD_RESTORE);
  assign dbg_rdata  = rdata_q;
  assign dbg_gnt    = dbg_wr_gnt_s || dbg_rd_gnt_s;

endmodule
